regfile_bist: RTL and testbench

Built-in self-test initiator for the 32×32 register file. On a start pulse it drives the register file's write port to load a per-register pattern into every register, then drives both read ports to read each register back and compares the results against expected values. It reports pass/fail, an error count and the first failing register. It sits beside `regfile` in the processor and owns the regfile control/data inputs while `busy` is high. The processor muxes its own control back in when `busy` is low.

---
 rtl/regfile_bist_pkg.sv | 29 ++
 rtl/regfile_bist.sv | 154 +++++++++++++++
 tb/tb_regfile_bist.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_bist_pkg.sv
// Shared state encoding, sizing constants and expected-value helper for the
// register-file built-in self-test.
package regfile_bist_pkg;

    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ADDR,
        RD_CHECK,
        DONE
    } bist_state_t;

    // Per-register pattern: base XOR the index replicated into every byte.
    function automatic logic [DATA_W-1:0] bist_expected(
        input logic [DATA_W-1:0]    pattern,
        input logic [REG_IDX_W-1:0] idx,
        input logic                 zero_reg
    );
        if (zero_reg && (idx == '0)) begin
            return '0;
        end
        return pattern ^ {4{3'b000, idx}};
    endfunction

endpackage

// File: rtl/regfile_bist.sv
// Self-test initiator for the register file: writes a per-register pattern,
// reads every register back on both ports and reports pass/fail statistics.
module regfile_bist
    import regfile_bist_pkg::*;
#(
    parameter int NUM_REGS   = regfile_bist_pkg::NUM_REGS,
    parameter int DATA_WIDTH = regfile_bist_pkg::DATA_W,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] pattern,
    output logic                  ctrl_writeEn,
    output logic [REG_IDX_W-1:0]  ctrl_writeReg,
    output logic [DATA_WIDTH-1:0] data_writeReg,
    output logic [REG_IDX_W-1:0]  ctrl_readRegA,
    output logic [REG_IDX_W-1:0]  ctrl_readRegB,
    input  logic [DATA_WIDTH-1:0] data_readRegA,
    input  logic [DATA_WIDTH-1:0] data_readRegB,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [6:0]            error_count,
    output logic [REG_IDX_W-1:0]  first_fail_reg
);

    localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(NUM_REGS - 1);

    bist_state_t           state, state_nx;
    logic [REG_IDX_W-1:0]  idx, idx_nx, idx_inc;
    logic [DATA_WIDTH-1:0] pat, pat_nx;
    logic [DATA_WIDTH-1:0] exp_a, exp_b;
    logic                  miss_a, miss_b;
    logic [6:0]            err_sum;

    logic                  we_nx, busy_nx, done_nx, pass_nx;
    logic [REG_IDX_W-1:0]  wreg_nx, ra_nx, rb_nx, ffr_nx;
    logic [DATA_WIDTH-1:0] wdata_nx;
    logic [6:0]            err_nx;

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        pat_nx   = pat;
        we_nx    = 1'b0;
        wreg_nx  = ctrl_writeReg;
        wdata_nx = data_writeReg;
        ra_nx    = ctrl_readRegA;
        rb_nx    = ctrl_readRegB;
        busy_nx  = busy;
        done_nx  = 1'b0;
        pass_nx  = pass;
        err_nx   = error_count;
        ffr_nx   = first_fail_reg;

        idx_inc = idx + 1'b1;
        exp_a   = bist_expected(pat, idx, ZERO_REG);
        exp_b   = bist_expected(pat, LAST_IDX - idx, ZERO_REG);
        miss_a  = (data_readRegA != exp_a);
        miss_b  = (data_readRegB != exp_b);
        err_sum = error_count + 7'(miss_a) + 7'(miss_b);

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = WRITE;
                    idx_nx   = '0;
                    pat_nx   = pattern;
                    err_nx   = '0;
                    ffr_nx   = '0;
                    pass_nx  = 1'b0;
                    busy_nx  = 1'b1;
                    we_nx    = 1'b1;
                    wreg_nx  = '0;
                    wdata_nx = bist_expected(pattern, '0, 1'b0);
                end
            end
            WRITE: begin
                if (idx == LAST_IDX) begin
                    state_nx = RD_ADDR;
                    idx_nx   = '0;
                    ra_nx    = '0;
                    rb_nx    = LAST_IDX;
                end else begin
                    idx_nx   = idx_inc;
                    we_nx    = 1'b1;
                    wreg_nx  = idx_inc;
                    wdata_nx = bist_expected(pat, idx_inc, 1'b0);
                end
            end
            RD_ADDR: begin
                state_nx = RD_CHECK;
            end
            RD_CHECK: begin
                err_nx = err_sum;
                // Only the first failing check records a register; counts only grow.
                if ((miss_a || miss_b) && (error_count == '0)) begin
                    ffr_nx = miss_a ? idx : (LAST_IDX - idx);
                end
                if (idx == LAST_IDX) begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    pass_nx  = (err_sum == '0);
                end else begin
                    state_nx = RD_ADDR;
                    idx_nx   = idx_inc;
                    ra_nx    = idx_inc;
                    rb_nx    = LAST_IDX - idx_inc;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state          <= IDLE;
            idx            <= '0;
            pat            <= '0;
            ctrl_writeEn   <= 1'b0;
            ctrl_writeReg  <= '0;
            data_writeReg  <= '0;
            ctrl_readRegA  <= '0;
            ctrl_readRegB  <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            error_count    <= '0;
            first_fail_reg <= '0;
        end else begin
            state          <= state_nx;
            idx            <= idx_nx;
            pat            <= pat_nx;
            ctrl_writeEn   <= we_nx;
            ctrl_writeReg  <= wreg_nx;
            data_writeReg  <= wdata_nx;
            ctrl_readRegA  <= ra_nx;
            ctrl_readRegB  <= rb_nx;
            busy           <= busy_nx;
            done           <= done_nx;
            pass           <= pass_nx;
            error_count    <= err_nx;
            first_fail_reg <= ffr_nx;
        end
    end

endmodule

// File: tb/tb_regfile_bist.sv
// Directed bench for regfile_bist: behavioural register files beside two DUTs
// (register 0 hardwired and writable) with queue-based write/result scoreboards.
module tb_regfile_bist;

    logic        clock = 1'b0;
    logic        ctrl_reset_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] pattern = '0;

    logic        we, we_z, busy, busy_z, done, done_z, pass, pass_z;
    logic [4:0]  wreg, wreg_z, ra, ra_z, rb, rb_z, ffr, ffr_z;
    logic [31:0] wdata, wdata_z, rda, rda_z, rdb, rdb_z;
    logic [6:0]  errs, errs_z;

    logic [31:0] rf   [0:31];
    logic [31:0] rf_z [0:31];
    logic        stuck_en = 1'b0;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;
    typedef struct {
        logic       p;
        logic [6:0] e;
        logic [4:0] f;
    } res_t;

    wr_t  wq[$];
    res_t rq[$];

    int n_chk = 0;
    int n_err = 0;
    int n_done = 0;
    int exp_dones = 0;

    always #5 clock = ~clock;

    regfile_bist #(.ZERO_REG(1'b1)) dut (
        .clock(clock), .ctrl_reset_n(ctrl_reset_n), .start(start), .pattern(pattern),
        .ctrl_writeEn(we), .ctrl_writeReg(wreg), .data_writeReg(wdata),
        .ctrl_readRegA(ra), .ctrl_readRegB(rb),
        .data_readRegA(rda), .data_readRegB(rdb),
        .busy(busy), .done(done), .pass(pass),
        .error_count(errs), .first_fail_reg(ffr)
    );

    regfile_bist #(.ZERO_REG(1'b0)) dut_z (
        .clock(clock), .ctrl_reset_n(ctrl_reset_n), .start(start), .pattern(pattern),
        .ctrl_writeEn(we_z), .ctrl_writeReg(wreg_z), .data_writeReg(wdata_z),
        .ctrl_readRegA(ra_z), .ctrl_readRegB(rb_z),
        .data_readRegA(rda_z), .data_readRegB(rdb_z),
        .busy(busy_z), .done(done_z), .pass(pass_z),
        .error_count(errs_z), .first_fail_reg(ffr_z)
    );

    // With pattern 0xFFFFFFFF exp(7) has bit 0 clear, so the fault holds it at 1.
    always @(posedge clock) begin
        if (we && (wreg != 5'd0)) begin
            rf[wreg] <= (stuck_en && (wreg == 5'd7)) ? (wdata | 32'h1) : wdata;
        end
        if (we_z) begin
            rf_z[wreg_z] <= wdata_z;
        end
    end

    assign rda   = (ra == 5'd0) ? 32'h0 : rf[ra];
    assign rdb   = (rb == 5'd0) ? 32'h0 : rf[rb];
    assign rda_z = rf_z[ra_z];
    assign rdb_z = rf_z[rb_z];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clock) begin
        if (ctrl_reset_n) begin
            if (we) begin
                if (wq.size() == 0) begin
                    check("write_unexpected", 32'd1, 32'd0);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    check("write_reg", {27'd0, wreg}, {27'd0, w.r});
                    check("write_data", wdata, w.d);
                end
            end
            if (done) begin
                n_done++;
                if (rq.size() == 0) begin
                    check("done_unexpected", 32'd1, 32'd0);
                end else begin
                    res_t r;
                    r = rq.pop_front();
                    check("res_pass", {31'd0, pass}, {31'd0, r.p});
                    check("res_errs", {25'd0, errs}, {25'd0, r.e});
                    check("res_first_fail", {27'd0, ffr}, {27'd0, r.f});
                    check("res_busy_low", {31'd0, busy}, 32'd0);
                end
                check("z0_done", {31'd0, done_z}, 32'd1);
                check("z0_pass", {31'd0, pass_z}, 32'd1);
                check("z0_errs", {25'd0, errs_z}, 32'd0);
            end
        end
    end

    task automatic run_start(input logic [31:0] p, input logic ep,
                             input logic [6:0] ee, input logic [4:0] ef);
        wr_t  w;
        res_t r;
        logic [4:0] ix;
        for (int i = 0; i < 32; i++) begin
            ix  = 5'(i);
            w.r = ix;
            w.d = p ^ {ix + 8'h0, ix + 8'h0, ix + 8'h0, ix + 8'h0};
            wq.push_back(w);
        end
        r.p = ep;
        r.e = ee;
        r.f = ef;
        rq.push_back(r);
        exp_dones++;
        @(negedge clock);
        pattern = p;
        start   = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int base;
        bit seen;
        base = n_done;
        seen = 1'b0;
        for (int k = 0; k < max_cycles; k++) begin
            @(posedge clock);
            #1;
            if (n_done > base) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_within_budget", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        ctrl_reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_wreg", {27'd0, wreg}, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_ra_rb", {22'd0, ra, rb}, 32'd0);
        check("rst_busy_done_pass", {29'd0, busy, done, pass}, 32'd0);
        check("rst_errs", {25'd0, errs}, 32'd0);
        check("rst_first_fail", {27'd0, ffr}, 32'd0);
        @(negedge clock);
        ctrl_reset_n = 1'b1;

        // Clean run with exact cycle positions relative to E0.
        run_start(32'h0000DEAD, 1'b1, 7'd0, 5'd0);
        check("e0_busy", {31'd0, busy}, 32'd1);
        check("e0_we", {31'd0, we}, 32'd1);
        check("e0_wreg", {27'd0, wreg}, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        check("e2_we", {31'd0, we}, 32'd1);
        check("e2_wreg", {27'd0, wreg}, 32'd2);
        check("e2_wdata", wdata, 32'h0202DCAF);
        repeat (30) @(posedge clock);
        #1;
        check("e32_we_low", {31'd0, we}, 32'd0);
        check("e32_ra", {27'd0, ra}, 32'd0);
        check("e32_rb", {27'd0, rb}, 32'd31);
        check("z0_reg0_raw", rf_z[0], 32'h0000DEAD);
        @(posedge clock);
        #1;
        check("e33_ra_held", {27'd0, ra}, 32'd0);
        @(posedge clock);
        #1;
        check("e34_ra", {27'd0, ra}, 32'd1);
        check("e34_rb", {27'd0, rb}, 32'd30);
        check("e34_reg1_data", rda, 32'h0101DFAC);
        repeat (62) @(posedge clock);
        #1;
        check("e96_done", {31'd0, done}, 32'd1);
        check("e96_busy", {31'd0, busy}, 32'd0);
        check("e96_pass", {31'd0, pass}, 32'd1);
        @(posedge clock);
        #1;
        check("e97_done_low", {31'd0, done}, 32'd0);

        // Stuck bit on register 7: seen on port A at i=7 and port B at i=24.
        stuck_en = 1'b1;
        run_start(32'hFFFFFFFF, 1'b0, 7'd2, 5'd7);
        wait_done(150);
        stuck_en = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("stuck_pass_held", {31'd0, pass}, 32'd0);
        check("stuck_errs_held", {25'd0, errs}, 32'd2);
        check("stuck_ffr_held", {27'd0, ffr}, 32'd7);

        // Start pulses mid-write and during DONE must both be ignored.
        run_start(32'h12345678, 1'b1, 7'd0, 5'd0);
        repeat (9) @(posedge clock);
        pattern = 32'hAAAAAAAA;
        start   = 1'b1;
        @(posedge clock);
        #1;
        start   = 1'b0;
        pattern = 32'h0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(posedge clock);
            #1;
        end
        check("busy_prot_done_seen", {31'd0, done}, 32'd1);
        pattern = 32'h55555555;
        start   = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("start_in_done_ignored", {30'd0, busy, we}, 32'd0);

        // Reset in the read phase aborts immediately.
        run_start(32'h0000DEAD, 1'b1, 7'd0, 5'd0);
        repeat (40) @(posedge clock);
        #1;
        check("pre_abort_busy", {31'd0, busy}, 32'd1);
        ctrl_reset_n = 1'b0;
        #1;
        check("abort_we", {31'd0, we}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_errs", {25'd0, errs}, 32'd0);
        wq.delete();
        rq.delete();
        exp_dones--;
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        run_start(32'hC3A5_0F1E, 1'b1, 7'd0, 5'd0);
        wait_done(150);

        repeat (2) @(posedge clock);
        #1;
        check("done_count", n_done, exp_dones);
        check("sb_results_drained", rq.size(), 32'd0);
        check("sb_writes_drained", wq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
